// File: rtl/bp_pht_ctrl_pkg.sv
// Shared types for the gshare PHT controller.
//   bp_cnt_t      : 2-bit saturating counter (bit 1 = predicted direction)
//   BP_CNT_WNT    : weakly-not-taken value used when the table is cleared
//   bp_upd_t      : queued table write {idx, wdata}
//   pht_inc/dec   : saturating counter step
package bp_pht_ctrl_pkg;

  localparam int BP_IDX_W = 9;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_CNT_WNT = 2'b01;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    bp_cnt_t             wdata;
  } bp_upd_t;

  typedef enum logic {ST_INIT, ST_RUN} bp_state_e;

  function automatic bp_cnt_t pht_inc(input bp_cnt_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic bp_cnt_t pht_dec(input bp_cnt_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_pht_ctrl_upd_fifo.sv
// bp_upd_fifo: synchronous FIFO of pending PHT writes.
//   push/push_data : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   flush          : empty the queue
//   full/empty/count, head : occupancy and head slot
//   entries        : raw storage, read-only, for lookup forwarding
module bp_upd_fifo
  import bp_pht_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  bp_upd_t               push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [AW-1:0]         head,
  output bp_upd_t [DEPTH-1:0]   entries
);

  bp_upd_t [DEPTH-1:0] mem;
  logic [AW-1:0]       wr_ptr;
  logic                push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign entries = mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      head   <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      head   <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  head   <= head + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; only slots inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: gshare pattern-history table controller.
// Owns a single-port table of 2-bit counters and the global history register.
// Fetch lookups and queued resolve-stage writes share the one table port;
// lookups win unless the update queue is nearly full. After reset or flush
// a clear sequence writes BP_CNT_WNT to every entry before ready_o rises.
// Ports:
//   clk, resetn (async, active low), flush_i, ready_o
//   lookup_*  : fetch request/handshake (index = pc[IDX_W+1:2] ^ GHR)
//   pred_*    : registered prediction, valid one cycle after accept
//   upd_*     : resolved-branch update into the write queue
// Build option: define BP_PHT_FWD_EN to forward the youngest queued write
// that matches a lookup index into pred_cnt_o / pred_taken_o.
module bp_pht_ctrl
  import bp_pht_ctrl_pkg::*;
#(
  parameter int PHT_ENTRIES = 512,
  parameter int IDX_W       = $clog2(PHT_ENTRIES),
  parameter int UPD_Q_DEPTH = 4,
  parameter int PC_W        = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  output logic             ready_o,
  input  logic             lookup_valid_i,
  input  logic [PC_W-1:0]  lookup_pc_i,
  output logic             lookup_ready_o,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [1:0]       pred_cnt_o,
  output logic [IDX_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [1:0]       upd_cnt_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [IDX_W-1:0] upd_ghr_i
);

  localparam int QAW = $clog2(UPD_Q_DEPTH);
  localparam int QCW = QAW + 1;

  bp_state_e  state;
  logic [IDX_W-1:0] ptr, ghr;
  bp_cnt_t    pht [PHT_ENTRIES];

  logic                      q_full, q_empty;
  logic [QCW-1:0]            q_count;
  logic [QAW-1:0]            q_head;
  bp_upd_t [UPD_Q_DEPTH-1:0] q_ent;
  bp_upd_t                   upd_ent, head_ent;

  logic             run, force_drain, lk_fire, up_fire, drain;
  logic [IDX_W-1:0] lk_idx;
  bp_cnt_t          tbl_rdata, lk_cnt, tbl_wdata;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;

  logic unused_bits;
  assign unused_bits = ^{lookup_pc_i[PC_W-1:IDX_W+2], lookup_pc_i[1:0], upd_ghr_i[IDX_W-1]};

  assign run         = (state == ST_RUN);
  // Keep one slot of headroom so an update can always be accepted while draining.
  assign force_drain = (q_count >= QCW'(UPD_Q_DEPTH - 1));
  assign lookup_ready_o = run && !force_drain;
  assign upd_ready_o    = run && !q_full;

  // Flush drops any handshake that coincides with it.
  assign lk_fire = lookup_valid_i && lookup_ready_o && !flush_i;
  assign up_fire = upd_valid_i && upd_ready_o && !flush_i;
  assign drain   = run && !flush_i && !lk_fire && !q_empty;

  assign lk_idx        = lookup_pc_i[IDX_W+1:2] ^ ghr;
  assign upd_ent.idx   = upd_idx_i;
  assign upd_ent.wdata = upd_taken_i ? pht_inc(upd_cnt_i) : pht_dec(upd_cnt_i);
  assign head_ent      = q_ent[q_head];

  bp_upd_fifo #(.DEPTH(UPD_Q_DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (up_fire),
    .push_data(upd_ent),
    .pop      (drain),
    .flush    (flush_i),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count),
    .head     (q_head),
    .entries  (q_ent)
  );

  // Single table port: clear writes in INIT, queue-head writes in RUN.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = ptr;
    tbl_wdata = BP_CNT_WNT;
    if (state == ST_INIT) begin
      tbl_we = 1'b1;
    end else if (drain) begin
      tbl_we    = 1'b1;
      tbl_waddr = head_ent.idx;
      tbl_wdata = head_ent.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) pht[tbl_waddr] <= tbl_wdata;
  end

  assign tbl_rdata = pht[lk_idx];

`ifdef BP_PHT_FWD_EN
  logic [QAW-1:0] slot;
  // Walk oldest to youngest so the youngest matching write wins.
  always_comb begin
    lk_cnt = tbl_rdata;
    slot   = '0;
    for (int i = 0; i < UPD_Q_DEPTH; i++) begin
      slot = q_head + QAW'(i);
      if ((QCW'(i) < q_count) && (q_ent[slot].idx == lk_idx)) lk_cnt = q_ent[slot].wdata;
    end
  end
`else
  assign lk_cnt = tbl_rdata;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_INIT;
      ptr          <= '0;
      ghr          <= '0;
      ready_o      <= 1'b0;
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_idx_o   <= '0;
      pred_cnt_o   <= '0;
      pred_ghr_o   <= '0;
    end else begin
      pred_valid_o <= lk_fire;
      if (lk_fire) begin
        pred_idx_o   <= lk_idx;
        pred_cnt_o   <= lk_cnt;
        pred_taken_o <= lk_cnt[1];
        pred_ghr_o   <= ghr;
      end
      if (flush_i) begin
        state   <= ST_INIT;
        ptr     <= '0;
        ghr     <= '0;
        ready_o <= 1'b0;
      end else if (state == ST_INIT) begin
        ptr <= ptr + IDX_W'(1);
        if (ptr == IDX_W'(PHT_ENTRIES - 1)) begin
          state   <= ST_RUN;
          ready_o <= 1'b1;
        end
      end else begin
        // Mispredict repair takes precedence over the speculative shift.
        if (up_fire && upd_mispredict_i) ghr <= {upd_ghr_i[IDX_W-2:0], upd_taken_i};
        else if (pred_valid_o)           ghr <= {ghr[IDX_W-2:0], pred_taken_o};
      end
    end
  end

endmodule

// File: doc/bp_pht_ctrl.md
Name: bp_pht_ctrl

Overview:
- Controller for the gshare pattern-history table (PHT) of 2-bit saturating counters (bp_cnt_t) used by fetch-stage branch prediction.
- Owns the table storage and a global history register (GHR).
- Table is single-access per cycle. The block arbitrates fetch lookups against buffered resolve-stage updates, and runs a sequential clear FSM after reset or flush.

Parameters:
- PHT_ENTRIES, 512, number of counters; power of two, >= 4.
- IDX_W, $clog2(PHT_ENTRIES), index width; GHR width equals IDX_W.
- UPD_Q_DEPTH, 4, update FIFO depth; power of two, >= 2.
- PC_W, 64, fetch PC width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush_i  in  1  re-initialise the table, GHR and queue.
- ready_o  out  1  table initialised and in RUN.
- lookup_valid_i  in  1  fetch requests a prediction.
- lookup_pc_i  in  PC_W  fetch PC.
- lookup_ready_o  out  1  lookup accepted this cycle when high with valid.
- pred_valid_o  out  1  prediction result valid.
- pred_taken_o  out  1  predicted direction, equal to counter bit 1.
- pred_idx_o  out  IDX_W  table index used.
- pred_cnt_o  out  2  counter value read.
- pred_ghr_o  out  IDX_W  GHR snapshot used for the index.
- upd_valid_i  in  1  resolved-branch update.
- upd_ready_o  out  1  update queue can accept.
- upd_idx_i  in  IDX_W  index from prediction.
- upd_cnt_i  in  2  counter value from prediction.
- upd_taken_i  in  1  actual direction.
- upd_mispredict_i  in  1  direction was mispredicted.
- upd_ghr_i  in  IDX_W  GHR snapshot from prediction.

Behaviour:
- Reset values: ready_o=0, lookup_ready_o=0, upd_ready_o=0, pred_valid_o=0, pred_taken_o=0, pred_idx_o=0, pred_cnt_o=0, pred_ghr_o=0. Internal: GHR=0, queue empty, FSM=INIT with clear pointer 0.
- INIT state:
  - Writes BP_CNT_WNT (2'b01) to entry ptr each cycle, ptr increments by 1.
  - After writing entry PHT_ENTRIES-1, the next state is RUN. ready_o rises exactly PHT_ENTRIES cycles after resetn deasserts.
  - lookup_ready_o and upd_ready_o stay 0 throughout INIT.
- flush_i:
  - In RUN: next state INIT with ptr=0, queue emptied, GHR=0. Any in-flight prediction is squashed, so pred_valid_o is 0 in the following cycle.
  - In INIT: ptr restarts at 0.
  - flush_i has priority over all same-cycle handshakes; they are dropped.
- Async reset mid-INIT or mid-RUN: immediately returns to the reset values above.
- Lookup:
  - Index = lookup_pc_i[IDX_W+1:2] XOR GHR, using the GHR value in the accept cycle N.
  - Table read happens in N. Outputs (pred_valid_o, taken, idx, cnt, ghr) are registered and appear in N+1 for exactly one cycle.
- Speculative GHR:
  - At the end of cycle N+1, GHR <= {GHR[IDX_W-2:0], pred_taken_o}.
  - A back-to-back lookup accepted in N+1 therefore indexes with the un-shifted GHR.
- Update enqueue:
  - upd_ready_o = RUN && queue not full.
  - On accept, the block enqueues {idx, wdata}, where wdata = upd_taken_i ? pht_inc(upd_cnt_i) : pht_dec(upd_cnt_i). Counters saturate at 2'b11 and 2'b00.
- Mispredict repair:
  - On an accepted update with upd_mispredict_i=1, GHR <= {upd_ghr_i[IDX_W-2:0], upd_taken_i}.
  - This overrides a same-cycle speculative shift.
- Arbitration (RUN, one table access per cycle):
  - force_drain = queue occupancy >= UPD_Q_DEPTH-1.
  - lookup_ready_o = RUN && !force_drain.
  - If a lookup is accepted, it owns the table; otherwise the queue head is written (if non-empty) and popped.
  - Enqueue and pop in the same cycle are legal; occupancy is unchanged.
- Queue ordering: strict FIFO. Two updates to the same index are written in order, so the last write wins.
- Hazard: without the optional feature, a lookup reads the table value, not any pending queued write.

Optional Feature:
- Macro: BP_PHT_FWD_EN.
- Defined: a lookup whose index matches one or more queued entries returns the wdata of the youngest match as pred_cnt_o and pred_taken_o. Timing is unchanged.
- Undefined: no forwarding; the stale table value is returned.

Decomposition:
- Shared package holds:
  - bp_cnt_t (logic [1:0]).
  - BP_CNT_WNT = 2'b01.
  - pht_inc/pht_dec functions.
  - bp_upd_t struct {idx, wdata}, parameterised by IDX_W via package constant BP_IDX_W.
- One sub-module: bp_upd_fifo, a synchronous FIFO of bp_upd_t.
  - Ports: push, pop, flush, full, empty, count.
  - Exposes all entries read-only for forwarding.

Test Plan:
- Reset: release resetn, PHT_ENTRIES=512 -> ready_o=0 for 512 cycles, 1 at cycle 512; every entry reads 2'b01.
- Lookup, GHR=0, pc=0x40 -> next cycle pred_valid_o=1, pred_idx_o=0x10, pred_cnt_o=2'b01, pred_taken_o=0; GHR becomes 0 after the shift.
- Saturation: updates idx 0x10 with (cnt=2'b11, taken=1) then (cnt=2'b00, taken=0) -> queued wdata 2'b11 then 2'b00; a later lookup reads 2'b00.
- Arbitration: lookup_valid_i held high, 3 updates pushed with UPD_Q_DEPTH=4 -> lookup_ready_o drops at occupancy 3, one drain occurs, then it re-asserts.
- Mispredict: upd_mispredict_i=1, upd_ghr_i=9'h0A5, upd_taken_i=1 in the same cycle as a speculative shift -> GHR=9'h14B.
- Flush mid-RUN with 2 queued updates and a lookup in flight -> pred_valid_o=0 next cycle, queue empty, ready_o=0 for 512 cycles, table all 2'b01.
